// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command-frame parser:
// default header byte, FSM state encoding and error codes.
package uart_cmd_pkg;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/uart_cmd_parser.sv
// Parses HEADER/ADDR/DHI/DLO/CSUM frames from a UART byte stream into register writes.
// Write or error strobe one cycle after the CSUM byte; no backpressure, one byte per rx_done_i.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  HEADER      = DEFAULT_HEADER,
  parameter logic [20:0] TIMEOUT_CYC = 21'd208320
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_done_i,
  output logic        reg_wr_en_o,
  output logic [7:0]  reg_addr_o,
  output logic [15:0] reg_wr_data_o,
  output logic        frame_err_o,
  output logic [1:0]  err_code_o,
  output logic        busy_o,
  output logic [7:0]  frame_cnt_o
);

  state_t      state;
  logic [7:0]  csum;
  logic [7:0]  addr_q;
  logic [7:0]  dhi_q;
  logic [7:0]  dlo_q;
  logic [20:0] tmo_cnt;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state         <= ST_IDLE;
      csum          <= 8'h00;
      addr_q        <= 8'h00;
      dhi_q         <= 8'h00;
      dlo_q         <= 8'h00;
      tmo_cnt       <= 21'd0;
      reg_wr_en_o   <= 1'b0;
      reg_addr_o    <= 8'h00;
      reg_wr_data_o <= 16'h0000;
      frame_err_o   <= 1'b0;
      err_code_o    <= 2'b00;
      frame_cnt_o   <= 8'h00;
    end else begin
      reg_wr_en_o <= 1'b0;
      frame_err_o <= 1'b0;
      if (state == ST_IDLE) begin
        tmo_cnt <= 21'd0;
        csum    <= 8'h00;
        if (rx_done_i && (rx_data_i == HEADER)) state <= ST_ADDR;
      end else if (rx_done_i) begin
        // An arriving byte always beats a coincident timeout expiry.
        tmo_cnt <= 21'd0;
        case (state)
          ST_ADDR: begin
            addr_q <= rx_data_i;
            csum   <= rx_data_i;
            state  <= ST_DHI;
          end
          ST_DHI: begin
            dhi_q <= rx_data_i;
            csum  <= csum + rx_data_i;
            state <= ST_DLO;
          end
          ST_DLO: begin
            dlo_q <= rx_data_i;
            csum  <= csum + rx_data_i;
            state <= ST_CSUM;
          end
          ST_CSUM: begin
            state <= ST_IDLE;
            if (rx_data_i == csum) begin
              reg_wr_en_o   <= 1'b1;
              reg_addr_o    <= addr_q;
              reg_wr_data_o <= {dhi_q, dlo_q};
              frame_cnt_o   <= frame_cnt_o + 8'd1;
            end else begin
              frame_err_o <= 1'b1;
              err_code_o  <= ERR_CSUM;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (tmo_cnt == TIMEOUT_CYC - 21'd1) begin
        state       <= ST_IDLE;
        tmo_cnt     <= 21'd0;
        frame_err_o <= 1'b1;
        err_code_o  <= ERR_TIMEOUT;
      end else begin
        tmo_cnt <= tmo_cnt + 21'd1;
      end
    end
  end

  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected strobes are queued as frames are sent
// and matched by a negedge monitor; each scenario task also checks timing inline.
module tb_uart_cmd_parser;

  localparam logic [20:0] T = 21'd40;

  logic        iclk = 1'b0;
  logic        irst_n = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_done_i = 1'b0;
  logic        reg_wr_en_o;
  logic [7:0]  reg_addr_o;
  logic [15:0] reg_wr_data_o;
  logic        frame_err_o;
  logic [1:0]  err_code_o;
  logic        busy_o;
  logic [7:0]  frame_cnt_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit          is_err;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  code;
  } ev_t;

  ev_t        q[$];
  logic [7:0] exp_cnt = 8'h00;

  uart_cmd_parser #(.HEADER(8'hA5), .TIMEOUT_CYC(T)) dut (
    .iclk(iclk), .irst_n(irst_n), .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
    .reg_wr_en_o(reg_wr_en_o), .reg_addr_o(reg_addr_o), .reg_wr_data_o(reg_wr_data_o),
    .frame_err_o(frame_err_o), .err_code_o(err_code_o), .busy_o(busy_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 iclk = ~iclk;

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge iclk) begin
    if (irst_n) begin
      if (reg_wr_en_o || frame_err_o) begin
        total++;
        if (reg_wr_en_o && frame_err_o) begin
          bad++;
          $display("FAIL both_strobes: wr=%b err=%b, required not both", reg_wr_en_o, frame_err_o);
        end else if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: wr=%b err=%b addr=%h data=%h code=%b, required none",
                   reg_wr_en_o, frame_err_o, reg_addr_o, reg_wr_data_o, err_code_o);
        end else begin
          ev_t e;
          e = q.pop_front();
          if (e.is_err) begin
            if (!frame_err_o || err_code_o !== e.code) begin
              bad++;
              $display("FAIL sb_err: wr=%b err=%b code=%b, required err code=%b",
                       reg_wr_en_o, frame_err_o, err_code_o, e.code);
            end
          end else begin
            if (!reg_wr_en_o || reg_addr_o !== e.addr || reg_wr_data_o !== e.data) begin
              bad++;
              $display("FAIL sb_write: wr=%b addr=%h data=%h, required write addr=%h data=%h",
                       reg_wr_en_o, reg_addr_o, reg_wr_data_o, e.addr, e.data);
            end
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data_i = b;
    rx_done_i = 1'b1;
    @(posedge iclk);
    #1;
    rx_done_i = 1'b0;
    rx_data_i = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] cs);
    ev_t        e;
    logic [7:0] sum;
    sum = a + hi + lo;
    e.addr = a;
    e.data = {hi, lo};
    if (sum == cs) begin
      e.is_err = 1'b0;
      e.code   = 2'b00;
      exp_cnt  = exp_cnt + 8'd1;
    end else begin
      e.is_err = 1'b1;
      e.code   = 2'b01;
    end
    q.push_back(e);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(hi);
    send_byte(lo);
    send_byte(cs);
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge iclk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d, required 0", name, q.size());
      q.delete();
    end
    total++;
    if (frame_cnt_o !== exp_cnt) begin
      bad++;
      $display("FAIL %s_cnt: frame_cnt=%h, required %h", name, frame_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({reg_wr_en_o, reg_addr_o, reg_wr_data_o, frame_err_o, err_code_o, busy_o, frame_cnt_o} !== 37'd0) begin
      bad++;
      $display("FAIL reset_outputs: wr=%b addr=%h data=%h err=%b code=%b busy=%b cnt=%h, required all 0",
               reg_wr_en_o, reg_addr_o, reg_wr_data_o, frame_err_o, err_code_o, busy_o, frame_cnt_o);
    end
    repeat (2) @(posedge iclk);
    #1;
    irst_n = 1'b1;
    @(posedge iclk);
    #1;
  endtask

  task automatic test_good_frame();
    send_frame(8'h10, 8'h12, 8'h34, 8'h56);
    total++;
    if (reg_wr_en_o !== 1'b1 || reg_addr_o !== 8'h10 || reg_wr_data_o !== 16'h1234 || frame_cnt_o !== 8'h01) begin
      bad++;
      $display("FAIL good_n1: wr=%b addr=%h data=%h cnt=%h, required 1 10 1234 01",
               reg_wr_en_o, reg_addr_o, reg_wr_data_o, frame_cnt_o);
    end
    @(posedge iclk);
    #1;
    total++;
    if (reg_wr_en_o !== 1'b0 || busy_o !== 1'b0 || reg_addr_o !== 8'h10 || reg_wr_data_o !== 16'h1234) begin
      bad++;
      $display("FAIL good_n2: wr=%b busy=%b addr=%h data=%h, required 0 0 10 1234",
               reg_wr_en_o, busy_o, reg_addr_o, reg_wr_data_o);
    end
    drain("good");
  endtask

  task automatic test_bad_csum();
    send_frame(8'h10, 8'h12, 8'h34, 8'h57);
    total++;
    if (frame_err_o !== 1'b1 || err_code_o !== 2'b01 || reg_wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL badcs_n1: err=%b code=%b wr=%b busy=%b, required 1 01 0 0",
               frame_err_o, err_code_o, reg_wr_en_o, busy_o);
    end
    @(posedge iclk);
    #1;
    total++;
    if (frame_err_o !== 1'b0 || err_code_o !== 2'b01 || reg_addr_o !== 8'h10 || reg_wr_data_o !== 16'h1234) begin
      bad++;
      $display("FAIL badcs_hold: err=%b code=%b addr=%h data=%h, required 0 01 10 1234",
               frame_err_o, err_code_o, reg_addr_o, reg_wr_data_o);
    end
    drain("badcs");
  endtask

  task automatic test_timeout();
    ev_t e;
    e.is_err = 1'b1;
    e.addr   = 8'h00;
    e.data   = 16'h0000;
    e.code   = 2'b10;
    q.push_back(e);
    send_byte(8'hA5);
    send_byte(8'h10);
    repeat (T - 1) @(posedge iclk);
    #1;
    total++;
    if (frame_err_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL tmo_early: err=%b busy=%b, required 0 1", frame_err_o, busy_o);
    end
    @(posedge iclk);
    #1;
    total++;
    if (frame_err_o !== 1'b1 || err_code_o !== 2'b10 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL tmo_fire: err=%b code=%b busy=%b, required 1 10 0", frame_err_o, err_code_o, busy_o);
    end
    @(posedge iclk);
    #1;
    send_frame(8'h20, 8'h00, 8'hFF, 8'h1F);
    total++;
    if (reg_wr_en_o !== 1'b1 || reg_addr_o !== 8'h20 || reg_wr_data_o !== 16'h00FF) begin
      bad++;
      $display("FAIL tmo_recover: wr=%b addr=%h data=%h, required 1 20 00ff",
               reg_wr_en_o, reg_addr_o, reg_wr_data_o);
    end
    drain("tmo");
  endtask

  task automatic test_garbage_wrap();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL garbage_busy: busy=%b, required 0", busy_o);
    end
    send_frame(8'hFF, 8'hFF, 8'h01, 8'hFF);
    total++;
    if (reg_wr_en_o !== 1'b1 || reg_addr_o !== 8'hFF || reg_wr_data_o !== 16'hFF01) begin
      bad++;
      $display("FAIL csum_wrap: wr=%b addr=%h data=%h, required 1 ff ff01",
               reg_wr_en_o, reg_addr_o, reg_wr_data_o);
    end
    drain("garbage");
  endtask

  task automatic test_simultaneous();
    send_byte(8'hA5);
    repeat (T - 1) @(posedge iclk);
    #1;
    // This byte is sampled on exactly the expiry edge.
    send_byte(8'h10);
    total++;
    if (frame_err_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL simul_accept: err=%b busy=%b, required 0 1", frame_err_o, busy_o);
    end
    begin
      ev_t e;
      e.is_err = 1'b0;
      e.addr   = 8'h10;
      e.data   = 16'h0203;
      e.code   = 2'b00;
      q.push_back(e);
      exp_cnt = exp_cnt + 8'd1;
    end
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h15);
    drain("simul");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h01, 8'hA5, 8'h00, 8'hA6);
    send_frame(8'h02, 8'h00, 8'h00, 8'h00);
    send_frame(8'h03, 8'h10, 8'h20, 8'h99);
    send_frame(8'h04, 8'h05, 8'h06, 8'h0F);
    drain("b2b");
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h12);
    irst_n = 1'b0;
    exp_cnt = 8'h00;
    #1;
    total++;
    if ({reg_wr_en_o, reg_addr_o, reg_wr_data_o, frame_err_o, err_code_o, busy_o, frame_cnt_o} !== 37'd0) begin
      bad++;
      $display("FAIL midrst_outputs: wr=%b addr=%h data=%h err=%b code=%b busy=%b cnt=%h, required all 0",
               reg_wr_en_o, reg_addr_o, reg_wr_data_o, frame_err_o, err_code_o, busy_o, frame_cnt_o);
    end
    @(posedge iclk);
    #1;
    irst_n = 1'b1;
    send_byte(8'h34);
    send_byte(8'h56);
    repeat (T + 4) @(posedge iclk);
    #1;
    total++;
    if (busy_o !== 1'b0 || reg_addr_o !== 8'h00 || err_code_o !== 2'b00) begin
      bad++;
      $display("FAIL midrst_after: busy=%b addr=%h code=%b, required 0 00 00", busy_o, reg_addr_o, err_code_o);
    end
    drain("midrst");
  endtask

  task automatic test_cnt_wrap();
    for (int i = 0; i < 256; i++) begin
      send_frame(i[7:0], 8'h00, 8'h01, i[7:0] + 8'd1);
      if (i == 254) begin
        total++;
        if (frame_cnt_o !== 8'hFF) begin
          bad++;
          $display("FAIL cnt_ff: frame_cnt=%h, required ff", frame_cnt_o);
        end
      end
    end
    total++;
    if (frame_cnt_o !== 8'h00) begin
      bad++;
      $display("FAIL cnt_wrap: frame_cnt=%h, required 00", frame_cnt_o);
    end
    drain("wrap");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_timeout();
    test_garbage_wrap();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_frame();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5, the frame start byte.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 21'd208320, the inter-byte timeout in iclk cycles (2 byte times at 9600 bps / 100 MHz).
REQ-003 SHALL have port iclk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-004 SHALL have port irst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_data_i, input, 8 bits: received byte, valid only while rx_done_i=1.
REQ-006 SHALL have port rx_done_i, input, 1 bit: single-cycle byte-valid strobe from the UART receiver.
REQ-007 SHALL have port reg_wr_en_o, output, 1 bit: single-cycle register-write strobe.
REQ-008 SHALL have port reg_addr_o, output, 8 bits: register address, stable from the strobe until the next strobe.
REQ-009 SHALL have port reg_wr_data_o, output, 16 bits: register data, stable from the strobe until the next strobe.
REQ-010 SHALL have port frame_err_o, output, 1 bit: single-cycle frame-error strobe.
REQ-011 SHALL have port err_code_o, output, 2 bits: 2'b01 = checksum error, 2'b10 = timeout; held until the next error.
REQ-012 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-013 SHALL have port frame_cnt_o, output, 8 bits: count of good frames, wrapping 8'hFF -> 8'h00.

Function
REQ-014 SHALL parse the 5-byte frame HEADER, ADDR, DHI, DLO, CSUM.
REQ-015 SHALL use FSM states IDLE, ADDR, DHI, DLO, CSUM, advancing one state per rx_done_i.
REQ-016 SHALL, in IDLE, go to ADDR when rx_done_i=1 and rx_data_i==HEADER, and silently discard any other byte without flagging an error.
REQ-017 SHALL treat a byte equal to HEADER in states ADDR to CSUM as ordinary data, with no resynchronisation.
REQ-018 SHALL accumulate the checksum as ADDR+DHI+DLO, 8 bits wide, carries discarded (modulo 256).
REQ-019 SHALL, on the CSUM byte matching the checksum, on cycle N (the cycle with rx_done_i=1):
- at N+1, drive reg_wr_en_o=1 for exactly one cycle, with reg_addr_o and reg_wr_data_o={DHI,DLO} valid in that same cycle;
- increment frame_cnt_o;
- return to IDLE.
REQ-020 SHALL, on the CSUM byte mismatching the checksum, at N+1 drive frame_err_o=1 for one cycle and err_code_o=2'b01, return to IDLE, and leave reg_* unchanged.
REQ-021 SHALL clear the timeout counter on every rx_done_i and on entry to IDLE, and count only while not in IDLE.
REQ-022 SHALL, when the counter reaches TIMEOUT_CYC-1 in a non-IDLE state, pulse frame_err_o for one cycle, set err_code_o=2'b10, and return to IDLE.
REQ-023 SHALL, when rx_done_i and timeout expiry occur in the same cycle, give rx_done_i priority: byte accepted, counter cleared, no error.
REQ-024 SHALL never assert reg_wr_en_o and frame_err_o in the same cycle.
REQ-025 SHALL, when rx_done_i arrives in the cycle reg_wr_en_o or frame_err_o is high, process that byte as the IDLE byte.

Reset
REQ-026 SHALL, while irst_n=0, immediately force state IDLE, all outputs 0, the checksum and timeout counter 0, and frame_cnt_o 8'h00.
REQ-027 SHALL abandon a partial frame on reset mid-frame, with no write and no error strobe after reset is released.
REQ-028 SHALL sample the first byte after irst_n deassertion in IDLE.

Structure
REQ-029 SHALL place the default HEADER, the FSM state encoding (3 bits) and the ERR_CSUM/ERR_TIMEOUT codes in shared package uart_cmd_pkg.
REQ-030 SHALL have no sub-module: the timeout counter is inline, and the byte source is instantiated beside it at parent level.
REQ-031 SHALL be implementable in about 150-250 lines of RTL.

Verification
REQ-032 Good frame: bytes A5 10 12 34 56 -> one reg_wr_en_o pulse one cycle after the last rx_done_i, addr 8'h10, data 16'h1234, frame_cnt_o=1, frame_err_o never high.
REQ-033 Bad checksum: bytes A5 10 12 34 57 -> frame_err_o pulse with err_code_o=2'b01, no reg_wr_en_o, busy_o=0 next cycle.
REQ-034 Timeout: bytes A5 10, then idle for TIMEOUT_CYC cycles -> frame_err_o pulse with err_code_o=2'b10; a following A5 20 00 FF 1F writes addr 8'h20, data 16'h00FF.
REQ-035 Garbage and wrap: bytes 00 FF 5A A5 FF FF 01 FF -> garbage discarded, checksum wraps to FF, write addr FF, data 16'hFF01; 256 good frames -> frame_cnt_o wraps to 8'h00.
REQ-036 Reset mid-frame: A5 10 12, irst_n pulsed low, then 34 56 -> no write and no error; outputs all 0 during reset.
REQ-037 Simultaneous events: rx_done_i coincident with the timeout-expiry cycle -> byte accepted and no error strobe.
